reg_writeback_queue: RTL and testbench

- Write-side companion of the register file: collects writeback requests from the ALU path and the variable-latency memory path, buffers them in order, and drives the register file write port.
- Outputs `reg_write_signal`/`Dir_write`/`Write_Data` are registered on posedge and held a full cycle, so the register file's negedge write captures them mid-cycle.
- Publishes a per-register pending mask for RAW stall logic.
- Optional forwarding lookup returns not-yet-written values.

---
 rtl/reg_writeback_queue.sv | 123 ++++++++++++
 tb/tb_reg_writeback_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the register file write port: in-order FIFO for ALU/memory results,
// a registered write stage and a pending-register mask. Define WB_BYPASS_EN to enable forwarding lookup.
module reg_writeback_queue #(
    parameter int Width = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [Width-1:0] alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_rd,
    input  logic [Width-1:0] mem_data,
    output logic             reg_write_signal,
    output logic [4:0]       Dir_write,
    output logic [Width-1:0] Write_Data,
    output logic [31:0]      pending,
    output logic             full,
    output logic             empty,
    input  logic [4:0]       lookup_dir,
    output logic             fwd_hit,
    output logic [Width-1:0] fwd_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]       rd;
        logic [Width-1:0] data;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   alu_slot;
    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    logic            pop;
    logic            mem_push;
    logic            alu_push;

    // Free slots include the head being drained this cycle; x0 requests are acknowledged but dropped.
    always_comb begin
        pop       = (count != '0);
        free      = CW'(DEPTH) - count + CW'(pop);
        mem_ready = reset && (free >= CW'(1));
        alu_ready = reset && ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));
        mem_push  = mem_valid && mem_ready && (mem_rd != 5'd0);
        alu_push  = alu_valid && alu_ready && (alu_rd != 5'd0);
        alu_slot  = wr_ptr + PW'(mem_push);
    end

    // NOTE: storage has no reset; validity lives entirely in count/rd_ptr, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (mem_push) fifo_q[wr_ptr]   <= '{rd: mem_rd, data: mem_data};
        if (alu_push) fifo_q[alu_slot] <= '{rd: alu_rd, data: alu_data};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            reg_write_signal <= 1'b0;
            Dir_write        <= 5'd0;
            Write_Data       <= '0;
        end else begin
            if (pop) begin
                reg_write_signal <= 1'b1;
                Dir_write        <= fifo_q[rd_ptr].rd;
                Write_Data       <= fifo_q[rd_ptr].data;
                rd_ptr           <= rd_ptr + PW'(1);
            end else begin
                reg_write_signal <= 1'b0;
            end
            wr_ptr <= wr_ptr + PW'(mem_push) + PW'(alu_push);
            count  <= count - CW'(pop) + CW'(mem_push) + CW'(alu_push);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0) && !reg_write_signal;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) pending[fifo_q[rd_ptr + PW'(i)].rd] = 1'b1;
        end
        if (reg_write_signal) pending[Dir_write] = 1'b1;
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the newest matching entry overrides the output stage.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (lookup_dir != 5'd0) begin
            if (reg_write_signal && (Dir_write == lookup_dir)) begin
                fwd_hit  = 1'b1;
                fwd_data = Write_Data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count) && (fifo_q[rd_ptr + PW'(i)].rd == lookup_dir)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fifo_q[rd_ptr + PW'(i)].data;
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_dir;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed steps plus randomized traffic
// compared against a queue-based reference model and a register file model.
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [4:0]    alu_rd = '0;
    logic [W-1:0]  alu_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [4:0]    mem_rd = '0;
    logic [W-1:0]  mem_data = '0;
    logic          reg_write_signal;
    logic [4:0]    Dir_write;
    logic [W-1:0]  Write_Data;
    logic [31:0]   pending;
    logic          full;
    logic          empty;
    logic [4:0]    lookup_dir = '0;
    logic          fwd_hit;
    logic [W-1:0]  fwd_data;

    reg_writeback_queue #(.Width(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .reg_write_signal(reg_write_signal), .Dir_write(Dir_write), .Write_Data(Write_Data),
        .pending(pending), .full(full), .empty(empty),
        .lookup_dir(lookup_dir), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Register file: writes on the negedge inside the output window.
    logic [31:0] rf [32] = '{default: 32'h0};
    always @(negedge clk) if (reg_write_signal) rf[Dir_write] <= Write_Data;

    // Reference model state.
    ent_t        mq[$];
    logic        exp_we   = 1'b0;
    logic [4:0]  exp_dir  = '0;
    logic [31:0] exp_data = '0;
    logic [31:0] mrf [32] = '{default: 32'h0};

    int total = 0;
    int bad   = 0;
    logic saw_full = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_pend;
        logic        e_hit;
        logic [31:0] e_fd;
        e_pend = '0;
        foreach (mq[i]) e_pend[mq[i].rd] = 1'b1;
        if (exp_we) e_pend[exp_dir] = 1'b1;
        e_hit = 1'b0;
        e_fd  = '0;
`ifdef WB_BYPASS_EN
        if (lookup_dir != 0) begin
            for (int i = mq.size() - 1; i >= 0 && !e_hit; i--) begin
                if (mq[i].rd == lookup_dir) begin
                    e_hit = 1'b1;
                    e_fd  = mq[i].data;
                end
            end
            if (!e_hit && exp_we && exp_dir == lookup_dir) begin
                e_hit = 1'b1;
                e_fd  = exp_data;
            end
        end
`endif
        check("reg_write_signal", reg_write_signal, exp_we);
        check("Dir_write", Dir_write, exp_dir);
        check("Write_Data", Write_Data, exp_data);
        check("pending", pending, e_pend);
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, mq.size() == 0 && !exp_we);
        check("fwd_hit", fwd_hit, e_hit);
        check("fwd_data", fwd_data, e_fd);
        if (full) saw_full = 1'b1;
    endtask

    // One clock: drive, check handshakes, advance model and DUT, check post-edge state.
    task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic [4:0] lk);
        int   sz, fr;
        logic ear, emr;
        ent_t e;
        reset = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md; lookup_dir = lk;
        #1;
        sz  = mq.size();
        fr  = DEPTH - sz + ((sz > 0) ? 1 : 0);
        emr = rst && (fr >= 1);
        ear = rst && ((fr >= 2) || (fr == 1 && !mv));
        check("alu_ready", alu_ready, ear);
        check("mem_ready", mem_ready, emr);
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            exp_we = 1'b0; exp_dir = '0; exp_data = '0;
        end else begin
            if (sz > 0) begin
                e = mq.pop_front();
                exp_we = 1'b1; exp_dir = e.rd; exp_data = e.data;
                mrf[e.rd] = e.data;
            end else begin
                exp_we = 1'b0;
            end
            if (mv && emr && mrd != 0) mq.push_back('{rd: mrd, data: md});
            if (av && ear && ard != 0) mq.push_back('{rd: ard, data: ad});
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic [4:0] lk);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, lk);
    endtask

    task automatic check_rf(input string tag, input int r, input logic [31:0] exp);
        @(negedge clk);
        #1;
        check(tag, rf[r], exp);
    endtask

    initial begin
        // Reset held two cycles with a pending ALU request.
        step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5);
        step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5);
        check("reset_empty", empty, 1'b1);
        check("reset_pending", pending, 32'h0);

        // Single ALU write to x5.
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0);
        check("single_pending5", pending[5], 1'b1);
        idle(5'd0);
        check("single_dir", Dir_write, 5'd5);
        check("single_data", Write_Data, 32'hDEADBEEF);
        idle(5'd0);
        check("single_pending_clear", pending[5], 1'b0);
        check_rf("rf_x5", 5, 32'hDEADBEEF);

        // Simultaneous requests to the same register: memory is older.
        step(1'b1, 1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11, 5'd3);
        idle(5'd3);
        check("same_rd_first", Write_Data, 32'h11);
        idle(5'd3);
        check("same_rd_second", Write_Data, 32'h22);
        idle(5'd3);
        check("same_rd_pending_clear", pending[3], 1'b0);
        check_rf("rf_x3", 3, 32'h22);

        // x0 request is acknowledged and dropped.
        step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 5'd0);
        idle(5'd0);
        check("x0_no_write", reg_write_signal, 1'b0);
        check_rf("rf_x0", 0, 32'h0);

        // Backpressure: both sources every cycle, distinct destinations.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 5'(10 + 2 * i), $urandom, 1'b1, 5'(11 + 2 * i), $urandom, 5'(10 + i));
        check("bp_saw_full", saw_full, 1'b1);
        #1;
        check("bp_alu_blocked", alu_ready, 1'b0);
        check("bp_mem_open", mem_ready, 1'b1);

        // Reset mid-stream discards everything.
        step(1'b0, 1'b1, 5'd20, 32'h5, 1'b1, 5'd21, 32'h6, 5'd0);
        idle(5'd0);
        check("midreset_no_write", reg_write_signal, 1'b0);
        check("midreset_empty", empty, 1'b1);
        idle(5'd0);

        // Bypass: rd=7 queued twice behind older entries.
        step(1'b1, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd1, 32'hA1, 5'd7);
        step(1'b1, 1'b1, 5'd7, 32'hB, 1'b1, 5'd7, 32'hA, 5'd7);
`ifdef WB_BYPASS_EN
        check("bypass_hit", fwd_hit, 1'b1);
        check("bypass_data", fwd_data, 32'hB);
`else
        check("bypass_off_hit", fwd_hit, 1'b0);
`endif
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
        check("bypass_x0_hit", fwd_hit, 1'b0);
        for (int i = 0; i < 4; i++) idle(5'd7);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) != 0),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 8; i++) idle(5'd0);
        @(negedge clk);
        #1;
        for (int r = 0; r < 32; r++) check($sformatf("rf_final_x%0d", r), rf[r], mrf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
